serial_ft_adder_ctrl: RTL and testbench
=======================================

Name: serial_ft_adder_ctrl

Overview:
- Bit-serial sequencer that sits directly upstream of the single-bit sift-out fault-tolerant full adder and consumes its outputs.
- Accepts two W-bit operands and presents one bit pair per cycle, LSB first, to the adder's in1/in2/cin.
- Feeds the registered carry back as the next cin and assembles the W-bit sum plus final carry.
- Pulses the adder's K input before each operation to purge the sift-out detector flops.

Parameters:
- W, 8, operand/result width in bits (W >= 2).
- CW, derived as $clog2(W)+1, bit-counter width.

Ports:
- clk  input  1  system clock; also clocks the adder's detector JK flops.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- a  input  W  operand A; captured on accepted start.
- b  input  W  operand B; captured on accepted start.
- cin_init  input  1  carry-in for bit 0; captured on accepted start.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle pulse when result/carry_out are updated.
- result  output  W  sum, held until the next completion.
- carry_out  output  1  final carry, held with result.
- fa_in1  output  1  bit to adder in1.
- fa_in2  output  1  bit to adder in2.
- fa_cin  output  1  carry to adder cin.
- fa_k  output  1  detector clear to adder K; high only in CLEAR.
- fa_sum  input  1  adder sum.
- fa_cout  input  1  adder cout.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; busy=0, done=0, result=0, carry_out=0, fa_k=0; fa_in1=fa_in2=fa_cin=0; all shift and count registers cleared. Reset mid-operation aborts the addition with no done pulse, and result returns to 0.
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - start=1 captures a→sh_a, b→sh_b, cin_init→carry, clears bit count, and moves to CLEAR.
  - start=0 stays in IDLE.
- CLEAR (exactly 1 cycle): fa_k=1, fa_in*=0, then moves to RUN.
- RUN (exactly W cycles):
  - fa_in1=sh_a[0], fa_in2=sh_b[0], fa_cin=carry, all driven from registers with no combinational input-to-output path.
  - At each edge: fa_sum shifts into sh_s MSB-side (after W shifts bit i sits at position i); carry<=fa_cout; sh_a and sh_b shift right; count increments.
  - When count==W-1 at the edge, move to DONE.
- DONE (1 cycle):
  - result<=sh_s and carry_out<=carry are registered on entry, so they are visible together with done=1.
  - Then returns to IDLE.
- Latency: an accepted start at edge n gives done high during the cycle after edge n+W+1, i.e. W+2 cycles from start to done.
- start while busy is ignored; start in the DONE cycle is ignored; start is honoured in the first IDLE cycle after DONE.
- Arithmetic: {carry_out,result} = a + b + cin_init, modulo 2^(W+1), assuming a fault-free or fault-masked adder.
- The block does not check adder correctness; masking is the adder's job.

Optional Feature:
- Macro SERIAL_FT_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0) = signed overflow = carry into MSB XOR final carry. The carry into the MSB is captured at the last RUN cycle as fa_cin; ovf is updated with result and held.
- Undefined: no ovf port and no extra register.

Decomposition:
- Shared package serial_ft_pkg holds:
  - state typedef with encodings IDLE=2'd0, CLEAR=2'd1, RUN=2'd2, DONE=2'd3;
  - constant FA_CLEAR_CYCLES=1.
- No sub-module; the fault-tolerant adder is instantiated alongside it by the parent, not inside this block.

Test Plan:
- W=8, a=8'h3C, b=8'h5A, cin_init=0, start pulse: fa_k high exactly 1 cycle, then 8 RUN cycles; done at cycle 10 with result=8'h96, carry_out=0.
- a=8'hFF, b=8'h01, cin_init=1: result=8'h01, carry_out=1. With SERIAL_FT_ADDER_OVF_EN, a=8'h7F, b=8'h01 gives ovf=1.
- Back-to-back: start held high continuously: second operation begins in the first IDLE cycle after DONE, and done pulses are 11 cycles apart. A start pulsed mid-RUN is ignored and result reflects only the first operands.
- rst asserted asynchronously during RUN cycle 4: outputs go to 0 immediately, no done pulse, and the next start behaves normally.
- Adder model with one module's sum stuck-at-1, a=8'h00, b=8'h00: result=8'h00 via masking. Confirm fa_k pulses once per operation and never during RUN.

Source files
------------

// File: rtl/serial_ft_adder_ctrl_pkg.sv
// serial_ft_pkg: shared state encoding and constants for the serial FT adder sequencer
package serial_ft_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;
  localparam int FA_CLEAR_CYCLES = 1;
endpackage

// File: rtl/serial_ft_adder_ctrl.sv
// serial_ft_adder_ctrl: LSB-first bit-serial sequencer driving the sift-out FT full adder.
// Optional SERIAL_FT_ADDER_OVF_EN adds a held signed-overflow output ovf.
module serial_ft_adder_ctrl
  import serial_ft_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin_init,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         carry_out,
  output logic         fa_in1,
  output logic         fa_in2,
  output logic         fa_cin,
  output logic         fa_k,
  input  logic         fa_sum,
  input  logic         fa_cout
`ifdef SERIAL_FT_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);
  localparam int CW = $clog2(W) + 1;
  state_e state_q, state_d;
  logic [W-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_s_q, sh_s_d, result_q, result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d;
  logic accept, run, last;
  always_comb begin
    accept = (state_q == IDLE) && start;
    run    = (state_q == RUN);
    last   = run && (cnt_q == CW'(W - 1));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE)  ? (start ? CLEAR : IDLE) :
              (state_q == CLEAR) ? RUN :
              (state_q == RUN)   ? (last ? DONE : RUN) : IDLE;
  // Result is latched from the next-state sum so the final bit lands together with done.
  always_comb begin
    sh_a_d   = accept ? a : run ? sh_a_q >> 1 : sh_a_q;
    sh_b_d   = accept ? b : run ? sh_b_q >> 1 : sh_b_q;
    sh_s_d   = accept ? '0 : run ? {fa_sum, sh_s_q[W-1:1]} : sh_s_q;
    carry_d  = accept ? cin_init : run ? fa_cout : carry_q;
    cnt_d    = accept ? '0 : run ? cnt_q + 1'b1 : cnt_q;
    result_d = last ? sh_s_d : result_q;
    cout_d   = last ? fa_cout : cout_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sh_s_q   <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      sh_s_q   <= sh_s_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
`ifdef SERIAL_FT_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  // carry_q during the last RUN cycle is the carry into the MSB
  always_comb ovf_d = last ? carry_q ^ fa_cout : ovf_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  assign ovf = ovf_q;
`endif
  always_comb begin
    busy      = state_q != IDLE;
    done      = state_q == DONE;
    fa_k      = state_q == CLEAR;
    fa_in1    = run & sh_a_q[0];
    fa_in2    = run & sh_b_q[0];
    fa_cin    = run & carry_q;
    result    = result_q;
    carry_out = cout_q;
  end
endmodule

// File: tb/tb_serial_ft_adder_ctrl.sv
// tb_serial_ft_adder_ctrl: randomized self-checking bench with a TMR-style adder model.
module tb_serial_ft_adder_ctrl;
  import serial_ft_pkg::*;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic cin_init = 1'b0;
  logic busy, done, carry_out, fa_in1, fa_in2, fa_cin, fa_k, fa_sum, fa_cout;
  logic [W-1:0] result;
  logic fault_en = 1'b0;
  logic s_good, s0;
  int tests = 0, fails = 0;
`ifdef SERIAL_FT_ADDER_OVF_EN
  logic ovf;
`endif

  serial_ft_adder_ctrl #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin_init(cin_init),
    .busy(busy), .done(done), .result(result), .carry_out(carry_out),
    .fa_in1(fa_in1), .fa_in2(fa_in2), .fa_cin(fa_cin), .fa_k(fa_k),
    .fa_sum(fa_sum), .fa_cout(fa_cout)
`ifdef SERIAL_FT_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  // Three-replica adder, replica 0 optionally stuck-at-1 on sum, majority voted.
  assign s_good  = fa_in1 ^ fa_in2 ^ fa_cin;
  assign s0      = fault_en ? 1'b1 : s_good;
  assign fa_sum  = (s0 & s_good) | (s0 & s_good) | (s_good & s_good);
  assign fa_cout = (fa_in1 & fa_in2) | (fa_cin & (fa_in1 ^ fa_in2));

  always #5 clk = ~clk;

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input bit glitch, input string nm);
    logic [W:0] e;
    int cyc;
    int kcnt;
    e = (W+1)'(av) + (W+1)'(bv) + (W+1)'(cv);
    @(negedge clk);
    a = av; b = bv; cin_init = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    kcnt = 0;
    while (!done && cyc < 40) begin
      if (fa_k) kcnt++;
      tests++;
      if (fa_k !== (cyc == 1)) begin
        fails++;
        $display("FAIL %s fa_k cyc%0d got %b exp %b", nm, cyc, fa_k, cyc == 1);
      end
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL %s busy cyc%0d got %b exp 1", nm, cyc, busy);
      end
      if (cyc >= 2 && cyc <= W + 1) begin
        tests++;
        if ({fa_in1, fa_in2} !== {av[cyc-2], bv[cyc-2]}) begin
          fails++;
          $display("FAIL %s fa_in cyc%0d got %b%b exp %b%b", nm, cyc, fa_in1, fa_in2, av[cyc-2], bv[cyc-2]);
        end
      end else if (cyc == 1) begin
        tests++;
        if ({fa_in1, fa_in2, fa_cin} !== 3'b000) begin
          fails++;
          $display("FAIL %s clear_in got %b%b%b exp 000", nm, fa_in1, fa_in2, fa_cin);
        end
      end
      if (cyc == 2) begin
        tests++;
        if (fa_cin !== cv) begin
          fails++;
          $display("FAIL %s fa_cin0 got %b exp %b", nm, fa_cin, cv);
        end
      end
      if (glitch && cyc == 5) begin
        a = ~av; b = ~bv; cin_init = ~cv; start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    tests++;
    if (cyc != W + 2 || kcnt != FA_CLEAR_CYCLES) begin
      fails++;
      $display("FAIL %s latency/kpulses got %0d/%0d exp %0d/%0d", nm, cyc, kcnt, W + 2, FA_CLEAR_CYCLES);
    end
    tests++;
    if ({carry_out, result} !== e) begin
      fails++;
      $display("FAIL %s sum got %h exp %h", nm, {carry_out, result}, e);
    end
`ifdef SERIAL_FT_ADDER_OVF_EN
    tests++;
    if (ovf !== ((av[W-1] == bv[W-1]) && (e[W-1] != av[W-1]))) begin
      fails++;
      $display("FAIL %s ovf got %b exp %b", nm, ovf, (av[W-1] == bv[W-1]) && (e[W-1] != av[W-1]));
    end
`endif
    @(negedge clk);
    tests++;
    if ({done, busy} !== 2'b00 || {carry_out, result} !== e) begin
      fails++;
      $display("FAIL %s after_done got d%b b%b %h exp d0 b0 %h", nm, done, busy, {carry_out, result}, e);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, fa_k, fa_in1, fa_in2, fa_cin, carry_out, result} !== '0) begin
      fails++;
      $display("FAIL reset outputs got %b exp 0", {busy, done, fa_k, fa_in1, fa_in2, fa_cin, carry_out, result});
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL idle got b%b d%b exp 00", busy, done);
    end
  endtask

  task automatic test_directed();
    run_op(8'h3C, 8'h5A, 1'b0, 1'b0, "basic");
    run_op(8'hFF, 8'h01, 1'b1, 1'b0, "carry");
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, "ovf");
    run_op(8'h80, 8'h80, 1'b0, 1'b0, "negovf");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, "rand");
  endtask

  task automatic test_midrun_start();
    run_op(8'h21, 8'h43, 1'b1, 1'b1, "midrun");
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [W:0] e1, e2;
    d1 = -1; d2 = -1;
    e1 = (W+1)'(8'h12) + (W+1)'(8'h34);
    e2 = (W+1)'(8'hA5) + (W+1)'(8'h7E) + (W+1)'(1'b1);
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin_init = 1'b0; start = 1'b1;
    for (int c = 1; c <= 60 && d2 < 0; c++) begin
      @(negedge clk);
      if (done && d1 < 0) begin
        d1 = c;
        tests++;
        if ({carry_out, result} !== e1) begin
          fails++;
          $display("FAIL b2b first got %h exp %h", {carry_out, result}, e1);
        end
        a = 8'hA5; b = 8'h7E; cin_init = 1'b1;
      end else if (done) begin
        d2 = c;
        tests++;
        if ({carry_out, result} !== e2) begin
          fails++;
          $display("FAIL b2b second got %h exp %h", {carry_out, result}, e2);
        end
      end
    end
    start = 1'b0;
    tests++;
    if (d1 != W + 2 || d2 - d1 != W + 3) begin
      fails++;
      $display("FAIL b2b spacing got %0d/%0d exp %0d/%0d", d1, d2 - d1, W + 2, W + 3);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    bit seen;
    run_op(8'h55, 8'h22, 1'b0, 1'b0, "prereset");
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; cin_init = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({busy, done, fa_k, fa_in1, fa_in2, fa_cin, carry_out, result} !== '0) begin
      fails++;
      $display("FAIL async_rst got %b exp 0", {busy, done, fa_k, fa_in1, fa_in2, fa_cin, carry_out, result});
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    tests++;
    if (seen || result !== '0) begin
      fails++;
      $display("FAIL post_rst activity got %b result %h exp 0 00", seen, result);
    end
    run_op(8'h9C, 8'h31, 1'b0, 1'b0, "after_rst");
  endtask

  task automatic test_fault_mask();
    fault_en = 1'b1;
    run_op(8'h00, 8'h00, 1'b0, 1'b0, "stuck_zero");
    run_op(W'($urandom), W'($urandom), 1'b0, 1'b0, "stuck_rand");
    fault_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_midrun_start();
    test_back_to_back();
    test_async_reset();
    test_fault_mask();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
